// File: rtl/delta_demod.sv
// Delta-stream demodulator: integrates one delta bit per strobe into a saturating
// accumulator and emits FRAME_LEN samples per frame. Optional macro: ADAPTIVE_STEP_EN.
module delta_demod #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned INIT      = 0,
  parameter int unsigned STEP      = 1,
  parameter int unsigned STEP_MAX  = 8
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             frame_start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             busy
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  if (FRAME_LEN < 2 || STEP_MAX < STEP) begin : g_cfg_err
    $error("delta_demod: FRAME_LEN must be >= 2 and STEP_MAX >= STEP");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_base;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] sample_d;
  logic             sv_d, fd_d, fa_d;
  logic [WIDTH-1:0] applied_step;

`ifdef ADAPTIVE_STEP_EN
  localparam logic [WIDTH:0] STEP_MAX_W = (WIDTH+1)'(STEP_MAX);

  logic [WIDTH-1:0] step_q, step_d, step_base, step_n;
  logic [1:0]       run_q, run_d, run_base, run_n;
  logic             prev_q, prev_d;
  logic [WIDTH:0]   dbl;
`endif

  // Add or subtract one step at WIDTH+1 bits and clamp to the unsigned range.
  function automatic logic [WIDTH-1:0] integrate(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] s,
                                                 input logic             up);
    logic [WIDTH:0] r;
    if (up) begin
      r = {1'b0, a} + {1'b0, s};
      return r[WIDTH] ? {WIDTH{1'b1}} : r[WIDTH-1:0];
    end else begin
      r = {1'b0, a} - {1'b0, s};
      return r[WIDTH] ? {WIDTH{1'b0}} : r[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sample_d     = sample_out;
    sv_d         = 1'b0;
    fd_d         = 1'b0;
    fa_d         = 1'b0;
    acc_base     = acc_q;
    cnt_base     = cnt_q;
    applied_step = WIDTH'(STEP);
`ifdef ADAPTIVE_STEP_EN
    step_d       = step_q;
    run_d        = run_q;
    prev_d       = prev_q;
    step_base    = step_q;
    run_base     = run_q;
    step_n       = step_q;
    run_n        = 2'd0;
    dbl          = '0;
`endif

    // A frame_start always restarts; in RUN it also reports the abort.
    if (frame_start) begin
      fa_d     = (state_q == RUN);
      state_d  = RUN;
      acc_base = WIDTH'(INIT);
      cnt_base = '0;
      acc_d    = acc_base;
      cnt_d    = '0;
`ifdef ADAPTIVE_STEP_EN
      step_base = WIDTH'(STEP);
      run_base  = 2'd0;
      step_d    = step_base;
      run_d     = 2'd0;
`endif
    end

    if (bit_valid && (frame_start || state_q == RUN)) begin
`ifdef ADAPTIVE_STEP_EN
      // Same polarity as the previous bit keeps the grown step; otherwise fall back.
      if (cnt_base != '0 && bit_in == prev_q) begin
        applied_step = step_base;
        step_n       = step_base;
        run_n        = run_base + 2'd1;
      end else begin
        applied_step = WIDTH'(STEP);
        step_n       = WIDTH'(STEP);
        run_n        = 2'd1;
      end
      if (run_n == 2'd3) begin
        dbl    = {step_n, 1'b0};
        step_n = (dbl > STEP_MAX_W) ? STEP_MAX_W[WIDTH-1:0] : dbl[WIDTH-1:0];
        run_n  = 2'd0;
      end
      step_d = step_n;
      run_d  = run_n;
      prev_d = bit_in;
`endif
      acc_d    = integrate(acc_base, applied_step, bit_in);
      sample_d = acc_d;
      sv_d     = 1'b1;
      cnt_d    = cnt_base + CW'(1);
      if (cnt_d == CW'(FRAME_LEN)) begin
        fd_d    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= IDLE;
      acc_q        <= WIDTH'(INIT);
      cnt_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sample_out   <= sample_d;
      sample_valid <= sv_d;
      frame_done   <= fd_d;
      frame_abort  <= fa_d;
    end
  end

`ifdef ADAPTIVE_STEP_EN
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      step_q <= WIDTH'(STEP);
      run_q  <= 2'd0;
      prev_q <= 1'b0;
    end else begin
      step_q <= step_d;
      run_q  <= run_d;
      prev_q <= prev_d;
    end
  end
`endif

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_delta_demod.sv
// Directed self-checking bench for delta_demod (default build or ADAPTIVE_STEP_EN).
module tb_delta_demod;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] sample_out, sample_hi;
  logic       sample_valid, frame_done, frame_abort, busy;
  logic       sv_hi, fd_hi, fa_hi, busy_hi;

  int checks = 0;
  int fails = 0;
  int fd_count = 0;

  localparam bit         BASIC_BITS [8] = '{1, 1, 1, 0, 1, 1, 0, 1};
  localparam logic [7:0] BASIC_EXP  [8] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
  localparam bit         MIX_BITS   [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
`ifdef ADAPTIVE_STEP_EN
  localparam logic [7:0] ALL1    [8] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9, 8'd13, 8'd17};
  localparam logic [7:0] MIX_EXP [8] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0};
  localparam logic [7:0] HI_DOWN [8] = '{8'd253, 8'd252, 8'd251, 8'd249, 8'd247, 8'd245, 8'd241, 8'd237};
`else
  localparam logic [7:0] ALL1    [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [7:0] MIX_EXP [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [7:0] HI_DOWN [8] = '{8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248, 8'd247, 8'd246};
`endif

  delta_demod dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .sample_out(sample_out), .sample_valid(sample_valid),
    .frame_done(frame_done), .frame_abort(frame_abort), .busy(busy)
  );

  delta_demod #(.INIT(254)) dut_hi (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .sample_out(sample_hi), .sample_valid(sv_hi),
    .frame_done(fd_hi), .frame_abort(fa_hi), .busy(busy_hi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_count++;

  // Present one cycle of inputs, then return 1ns after the consuming edge.
  task automatic step_in(input logic fs, input logic bv, input logic b);
    frame_start = fs; bit_valid = bv; bit_in = b;
    @(posedge clk); #1;
    frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (sample_out !== 8'd0) begin fails++; $display("FAIL reset_sample got %0d want 0", sample_out); end
    checks++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (frame_abort !== 1'b0) begin fails++; $display("FAIL reset_abort got %b want 0", frame_abort); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    step_in(1'b1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || sample_valid !== 1'b0) begin fails++; $display("FAIL basic_start busy=%b valid=%b want 1/0", busy, sample_valid); end
    for (int i = 0; i < 8; i++) begin
      step_in(1'b0, 1'b1, BASIC_BITS[i]);
      checks++; if (sample_valid !== 1'b1 || sample_out !== BASIC_EXP[i]) begin fails++; $display("FAIL basic_sample[%0d] got %0d/%b want %0d/1", i, sample_out, sample_valid, BASIC_EXP[i]); end
      checks++; if (frame_done !== (i == 7) || busy !== (i != 7)) begin fails++; $display("FAIL basic_flags[%0d] done=%b busy=%b want %b/%b", i, frame_done, busy, i == 7, i != 7); end
    end
    step_in(1'b0, 1'b0, 1'b0);
    checks++; if (sample_valid !== 1'b0 || frame_done !== 1'b0 || sample_out !== 8'd4 || busy !== 1'b0) begin fails++; $display("FAIL basic_after valid=%b done=%b sample=%0d busy=%b want 0/0/4/0", sample_valid, frame_done, sample_out, busy); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 8; i++) begin
      step_in(i == 0, 1'b1, 1'b0);
      checks++; if (sample_valid !== 1'b1 || sample_out !== 8'd0) begin fails++; $display("FAIL under_sample[%0d] got %0d/%b want 0/1", i, sample_out, sample_valid); end
      checks++; if (sample_hi !== HI_DOWN[i]) begin fails++; $display("FAIL hi_down[%0d] got %0d want %0d", i, sample_hi, HI_DOWN[i]); end
      checks++; if (frame_done !== (i == 7)) begin fails++; $display("FAIL under_done[%0d] got %b want %b", i, frame_done, i == 7); end
    end
    for (int i = 0; i < 8; i++) begin
      step_in(i == 0, 1'b1, 1'b1);
      checks++; if (sample_out !== ALL1[i]) begin fails++; $display("FAIL all1[%0d] got %0d want %0d", i, sample_out, ALL1[i]); end
      checks++; if (sv_hi !== 1'b1 || sample_hi !== 8'd255) begin fails++; $display("FAIL over_sample[%0d] got %0d/%b want 255/1", i, sample_hi, sv_hi); end
      checks++; if (fd_hi !== (i == 7)) begin fails++; $display("FAIL over_done[%0d] got %b want %b", i, fd_hi, i == 7); end
    end
    step_in(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    int base_fd;
    base_fd = fd_count;
    step_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_in(1'b0, 1'b1, 1'b1);
      checks++; if (sample_out !== ALL1[i] || frame_abort !== 1'b0) begin fails++; $display("FAIL abort_pre[%0d] got %0d/%b want %0d/0", i, sample_out, frame_abort, ALL1[i]); end
    end
    step_in(1'b1, 1'b1, 1'b1);
    checks++; if (frame_abort !== 1'b1) begin fails++; $display("FAIL abort_pulse got %b want 1", frame_abort); end
    checks++; if (sample_valid !== 1'b1 || sample_out !== ALL1[0] || frame_done !== 1'b0) begin fails++; $display("FAIL abort_first got %0d/%b done=%b want %0d/1 done=0", sample_out, sample_valid, frame_done, ALL1[0]); end
    for (int i = 1; i < 8; i++) begin
      step_in(1'b0, 1'b1, 1'b1);
      checks++; if (sample_out !== ALL1[i] || frame_abort !== 1'b0 || frame_done !== (i == 7)) begin fails++; $display("FAIL abort_run[%0d] got %0d abort=%b done=%b want %0d/0/%b", i, sample_out, frame_abort, frame_done, ALL1[i], i == 7); end
    end
    step_in(1'b0, 1'b0, 1'b0);
    checks++; if (fd_count !== base_fd + 1) begin fails++; $display("FAIL abort_done_count got %0d want %0d", fd_count - base_fd, 1); end
  endtask

  task automatic test_reset_mid;
    step_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step_in(1'b0, 1'b1, 1'b1);
    checks++; if (sample_out !== ALL1[3] || busy !== 1'b1) begin fails++; $display("FAIL mid_pre got %0d/%b want %0d/1", sample_out, busy, ALL1[3]); end
    bit_valid = 1'b1; bit_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sample_out !== 8'd0 || sample_valid !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset sample=%0d valid=%b done=%b abort=%b busy=%b want all 0", sample_out, sample_valid, frame_done, frame_abort, busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_in(1'b0, 1'b1, 1'b1);
      checks++; if (sample_valid !== 1'b0 || busy !== 1'b0 || sample_out !== 8'd0) begin fails++; $display("FAIL idle_ignore[%0d] valid=%b busy=%b sample=%0d want 0/0/0", i, sample_valid, busy, sample_out); end
    end
  endtask

  task automatic test_gaps;
    step_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step_in(1'b0, 1'b1, 1'b1);
      checks++; if (sample_valid !== 1'b1 || sample_out !== ALL1[i]) begin fails++; $display("FAIL gap_sample[%0d] got %0d/%b want %0d/1", i, sample_out, sample_valid, ALL1[i]); end
      for (int g = 0; g < i % 6; g++) begin
        step_in(1'b0, 1'b0, 1'b0);
        checks++; if (sample_valid !== 1'b0 || sample_out !== ALL1[i]) begin fails++; $display("FAIL gap_hold[%0d] got %0d/%b want %0d/0", i, sample_out, sample_valid, ALL1[i]); end
      end
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_busy got %b want 0", busy); end
  endtask

  task automatic test_mixed;
    step_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step_in(1'b0, 1'b1, MIX_BITS[i]);
      checks++; if (sample_out !== MIX_EXP[i] || frame_done !== (i == 7)) begin fails++; $display("FAIL mixed[%0d] got %0d done=%b want %0d done=%b", i, sample_out, frame_done, MIX_EXP[i], i == 7); end
    end
    step_in(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_abort;
    test_reset_mid;
    test_gaps;
    test_mixed;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
